// File: rtl/decode_in_drive_pkg.sv
// Shared types and defaults for the decode-stage input driver.
package decode_in_drive_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    // LC-3 NOP encoding
    localparam logic [DEF_DATA_W-1:0] DEF_IDLE_INSTR = 16'h0000;

    typedef enum logic {
        IDLE_HOLD = 1'b0,
        IDLE_NOP  = 1'b1
    } idle_mode_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] npc;
        logic [DEF_DATA_W-1:0] instr;
    } decode_in_txn_t;

endpackage

// File: rtl/decode_in_txn_fifo.sv
// Synchronous FIFO of (npc, instr) transactions; a push is never visible to a pop on the same edge.
module decode_in_txn_fifo
    import decode_in_drive_pkg::*;
#(
    parameter type         txn_t = decode_in_txn_t,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  txn_t             push_data,
    input  logic             pop,
    output logic             nonempty,
    output txn_t             head,
    output logic [LVL_W-1:0] level
);

    txn_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    // Both qualifiers look only at the registered level, so a same-edge pop
    // cannot free a slot and a same-edge push cannot feed a pop.
    assign push_ready = (r_level < LVL_W'(DEPTH));
    assign nonempty   = (r_level != '0);
    assign w_push     = push_valid && push_ready;
    assign w_pop      = pop && nonempty;
    assign head       = r_mem[r_rd_ptr];
    assign level      = r_level;

    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

endmodule

// File: rtl/decode_in_drive_queue.sv
// Buffered, stall-aware driver presenting queued (npc, instr) pairs to the decode stage.
module decode_in_drive_queue
    import decode_in_drive_pkg::*;
#(
    parameter int unsigned       DATA_W     = DEF_DATA_W,
    parameter int unsigned       DEPTH      = 8,
    parameter int unsigned       IDLE_MODE  = 0,
    parameter logic [DATA_W-1:0] IDLE_INSTR = DATA_W'(DEF_IDLE_INSTR),
    localparam int unsigned      LVL_W      = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_npc,
    input  logic [DATA_W-1:0] push_instr,
    input  logic              enable_decode,
    output logic [DATA_W-1:0] npc_in,
    output logic [DATA_W-1:0] instr_dout,
    output logic              out_valid,
    output logic [LVL_W-1:0]  level,
    output logic [31:0]       drive_count,
    output logic              underflow
);

    typedef struct packed {
        logic [DATA_W-1:0] npc;
        logic [DATA_W-1:0] instr;
    } drive_txn_t;

    localparam idle_mode_e IdleMode = idle_mode_e'(IDLE_MODE[0]);

    drive_txn_t        w_push_txn;
    drive_txn_t        w_head;
    logic              w_nonempty;
    logic [DATA_W-1:0] r_npc;
    logic [DATA_W-1:0] r_instr;
    logic              r_valid;
    logic              r_underflow;
    logic [31:0]       r_count;

    assign w_push_txn = '{npc: push_npc, instr: push_instr};

    decode_in_txn_fifo #(
        .txn_t (drive_txn_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (w_push_txn),
        .pop        (enable_decode),
        .nonempty   (w_nonempty),
        .head       (w_head),
        .level      (level)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_npc       <= '0;
            r_instr     <= IDLE_INSTR;
            r_valid     <= 1'b0;
            r_underflow <= 1'b0;
            r_count     <= '0;
        end else begin
            r_underflow <= 1'b0;
            if (enable_decode) begin
                if (w_nonempty) begin
                    r_npc   <= w_head.npc;
                    r_instr <= w_head.instr;
                    r_valid <= 1'b1;
                    r_count <= r_count + 32'd1;
                end else begin
                    // Starved request: npc always holds, instr depends on idle mode.
                    r_valid     <= 1'b0;
                    r_underflow <= 1'b1;
                    if (IdleMode == IDLE_NOP) begin
                        r_instr <= IDLE_INSTR;
                    end
                end
            end
        end
    end

    assign npc_in      = r_npc;
    assign instr_dout  = r_instr;
    assign out_valid   = r_valid;
    assign drive_count = r_count;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_decode_in_drive_queue.sv
// Randomised self-checking bench: both idle modes driven in lockstep against a queue model.
module tb_decode_in_drive_queue;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam logic [DW-1:0] IDLE = 16'h0000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          push_valid = 1'b0;
    logic [DW-1:0] push_npc = '0;
    logic [DW-1:0] push_instr = '0;
    logic          enable_decode = 1'b0;

    logic          h_ready, n_ready;
    logic [DW-1:0] h_npc, n_npc, h_instr, n_instr;
    logic          h_valid, n_valid, h_under, n_under;
    logic [LW-1:0] h_level, n_level;
    logic [31:0]   h_count, n_count;

    always #5 clock = ~clock;

    decode_in_drive_queue #(
        .DATA_W(DW), .DEPTH(DEPTH), .IDLE_MODE(0), .IDLE_INSTR(IDLE)
    ) u_dut_hold (
        .clock(clock), .reset(reset), .push_valid(push_valid), .push_ready(h_ready),
        .push_npc(push_npc), .push_instr(push_instr), .enable_decode(enable_decode),
        .npc_in(h_npc), .instr_dout(h_instr), .out_valid(h_valid), .level(h_level),
        .drive_count(h_count), .underflow(h_under)
    );

    decode_in_drive_queue #(
        .DATA_W(DW), .DEPTH(DEPTH), .IDLE_MODE(1), .IDLE_INSTR(IDLE)
    ) u_dut_nop (
        .clock(clock), .reset(reset), .push_valid(push_valid), .push_ready(n_ready),
        .push_npc(push_npc), .push_instr(push_instr), .enable_decode(enable_decode),
        .npc_in(n_npc), .instr_dout(n_instr), .out_valid(n_valid), .level(n_level),
        .drive_count(n_count), .underflow(n_under)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: a plain queue of {npc, instr} plus the visible pin state.
    logic [2*DW-1:0] m_q[$];
    logic [DW-1:0]   m_npc = '0;
    logic [DW-1:0]   m_instr_hold = IDLE;
    logic [DW-1:0]   m_instr_nop = IDLE;
    logic            m_valid = 1'b0;
    logic            m_under = 1'b0;
    logic [31:0]     m_count = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic pv, input logic [DW-1:0] pn,
                              input logic [DW-1:0] pi, input logic en);
        logic [2*DW-1:0] t;
        bit full;
        if (rst) begin
            m_q.delete();
            m_npc = '0;
            m_instr_hold = IDLE;
            m_instr_nop = IDLE;
            m_valid = 1'b0;
            m_under = 1'b0;
            m_count = '0;
        end else begin
            full = (m_q.size() == DEPTH);
            m_under = 1'b0;
            if (en) begin
                if (m_q.size() > 0) begin
                    t = m_q.pop_front();
                    m_npc = t[2*DW-1:DW];
                    m_instr_hold = t[DW-1:0];
                    m_instr_nop = t[DW-1:0];
                    m_valid = 1'b1;
                    m_count = m_count + 32'd1;
                end else begin
                    m_valid = 1'b0;
                    m_under = 1'b1;
                    m_instr_nop = IDLE;
                end
            end
            if (pv && !full) m_q.push_back({pn, pi});
        end
    endtask

    task automatic compare_all();
        check("hold.npc", 64'(h_npc), 64'(m_npc));
        check("hold.instr", 64'(h_instr), 64'(m_instr_hold));
        check("hold.valid", 64'(h_valid), 64'(m_valid));
        check("hold.underflow", 64'(h_under), 64'(m_under));
        check("hold.level", 64'(h_level), 64'(m_q.size()));
        check("hold.push_ready", 64'(h_ready), 64'(m_q.size() < DEPTH));
        check("hold.drive_count", 64'(h_count), 64'(m_count));
        check("nop.npc", 64'(n_npc), 64'(m_npc));
        check("nop.instr", 64'(n_instr), 64'(m_instr_nop));
        check("nop.valid", 64'(n_valid), 64'(m_valid));
        check("nop.underflow", 64'(n_under), 64'(m_under));
        check("nop.level", 64'(n_level), 64'(m_q.size()));
        check("nop.drive_count", 64'(n_count), 64'(m_count));
    endtask

    task automatic step(input logic rst, input logic pv, input logic [DW-1:0] pn,
                        input logic [DW-1:0] pi, input logic en);
        reset = rst;
        push_valid = pv;
        push_npc = pn;
        push_instr = pi;
        enable_decode = en;
        @(posedge clock);
        model_edge(rst, pv, pn, pi, en);
        #1;
        compare_all();
    endtask

    initial begin
        int pv_pct;
        int en_pct;
        @(posedge clock);
        #1;
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        check("reset.instr", 64'(h_instr), 64'(IDLE));
        check("reset.ready", 64'(h_ready), 64'd1);

        // Three pushes, then drain with enable held high.
        step(1'b0, 1'b1, 16'h3000, 16'h1020, 1'b0);
        step(1'b0, 1'b1, 16'h3001, 16'h5062, 1'b0);
        step(1'b0, 1'b1, 16'h3002, 16'h0E05, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        check("seq.first_npc", 64'(h_npc), 64'h3000);
        check("seq.first_instr", 64'(h_instr), 64'h1020);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        check("seq.third_instr", 64'(h_instr), 64'h0E05);
        check("seq.count", 64'(h_count), 64'd3);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        check("seq.underflow", 64'(h_under), 64'd1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        check("seq.underflow_clear", 64'(h_under), 64'd0);

        // Fill with decode stalled; the ninth push is dropped.
        step(1'b1, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 16'h4000 + 16'(i), 16'h7000 + 16'(i), 1'b0);
        check("full.level", 64'(h_level), 64'd8);
        check("full.ready", 64'(h_ready), 64'd0);
        check("full.npc", 64'(h_npc), 64'h0);

        // Pop and refused push on the same edge, accepted one cycle later.
        step(1'b0, 1'b1, 16'h5000, 16'h5555, 1'b1);
        check("full_pop.level", 64'(h_level), 64'd7);
        check("full_pop.npc", 64'(h_npc), 64'h4000);
        step(1'b0, 1'b1, 16'h5000, 16'h5555, 1'b0);
        check("full_pop.accept", 64'(h_level), 64'd8);

        // Stall pattern 1,0,0,1.
        step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b0);
        check("stall.hold_npc", 64'(h_npc), 64'h4001);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        check("stall.next_npc", 64'(h_npc), 64'h4002);

        // Idle behaviour for both modes.
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b1, 16'h3004, 16'h1234, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        check("idle.nop_instr", 64'(n_instr), 64'h0000);
        check("idle.hold_instr", 64'(h_instr), 64'h1234);
        check("idle.npc", 64'(n_npc), 64'h3004);
        check("idle.valid", 64'(n_valid), 64'd0);
        check("idle.underflow", 64'(n_under), 64'd1);

        // Reset discards queued pairs.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h6000 + 16'(i), 16'h6100 + 16'(i), 1'b0);
        step(1'b1, 1'b1, 16'hDEAD, 16'hBEEF, 1'b1);
        check("rst.level", 64'(h_level), 64'd0);
        check("rst.count", 64'(h_count), 64'd0);
        step(1'b0, 1'b1, 16'h6500, 16'h6501, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        check("rst.first_npc", 64'(h_npc), 64'h6500);

        // Randomised phases with varying producer/consumer pressure.
        for (int ph = 0; ph < 8; ph++) begin
            pv_pct = (ph % 2 == 0) ? 80 : 30;
            en_pct = (ph % 4 < 2) ? 40 : 85;
            for (int i = 0; i < 400; i++) begin
                step(($urandom_range(0, 149) == 0), ($urandom_range(0, 99) < pv_pct),
                     DW'($urandom), DW'($urandom), ($urandom_range(0, 99) < en_pct));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
